// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM encoding, the fetch payload struct and reset/NOP constants.
package instr_fetch_pkg;

    localparam logic [31:0] CORE_NOP             = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP              = 32'h0000_0004;

    typedef enum logic [1:0] {
        IF_STATE_IDLE  = 2'd0,
        IF_STATE_WAIT  = 2'd1,
        IF_STATE_FLUSH = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
    } fetch_t;

    localparam fetch_t FETCH_RESET = '{instr: CORE_NOP, pc: 32'h0, exc: 1'b0};

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifu_skid_buffer.sv
// Output register plus one-entry skid buffer between fetch and decode.
// Latency: a word presented in cycle N is visible on out_* in cycle N+1.
// Backpressure: out_* hold under stall; one arriving word parks in the skid entry.
module ifu_skid_buffer
    import instr_fetch_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   in_vld_i,
    input  fetch_t in_dat_i,
    input  logic   flush_i,
    input  logic   stall_i,
    output logic   out_vld_o,
    output fetch_t out_dat_o,
    output logic   skid_vld_o
);

    logic   out_vld_q, out_vld_d;
    fetch_t out_dat_q, out_dat_d;
    logic   skid_vld_q, skid_vld_d;
    fetch_t skid_dat_q, skid_dat_d;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        // A flush may carry a word of its own (the misalignment exception).
        if (flush_i) begin
            skid_vld_d = 1'b0;
            out_vld_d  = in_vld_i;
            if (in_vld_i) begin
                out_dat_d = in_dat_i;
            end
        end else if (!out_vld_q || !stall_i) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                skid_vld_d = in_vld_i;
                if (in_vld_i) begin
                    skid_dat_d = in_dat_i;
                end
            end else begin
                out_vld_d = in_vld_i;
                if (in_vld_i) begin
                    out_dat_d = in_dat_i;
                end
            end
        end else if (in_vld_i) begin
            skid_vld_d = 1'b1;
            skid_dat_d = in_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= FETCH_RESET;
            skid_vld_q <= 1'b0;
            skid_dat_q <= FETCH_RESET;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end

    assign out_vld_o  = out_vld_q;
    assign out_dat_o  = out_dat_q;
    assign skid_vld_o = skid_vld_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, one outstanding ibus read, skid-buffered ID handoff.
// Latency: rvalid in cycle N gives if_valid in cycle N+1; redirect flushes in one cycle.
// Backpressure: id_stall holds if_*; no request is issued once the skid entry is in use.
// Optional IF_MISALIGN_EXC_EN: misaligned redirects raise if_exc_misalign and halt fetch.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_gnt,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_exc_misalign
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        halt_q, halt_d;

    logic [31:0] redir_tgt;
    logic        mis_redir;
    logic        deliver;
    logic        skid_fill;
    logic        slot_free;
    logic        gnt_ok;
    logic        skid_vld;
    logic        buf_in_vld;
    fetch_t      buf_in_dat;
    fetch_t      buf_out_dat;

`ifdef IF_MISALIGN_EXC_EN
    assign mis_redir = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign mis_redir = 1'b0;
`endif

    always_comb begin
        redir_tgt = word_align(redirect_pc);
        deliver   = (state_q == IF_STATE_WAIT) && ibus_rvalid && !redirect;
        // A word about to park in the skid entry must not have a successor in flight.
        skid_fill = deliver && if_valid && id_stall;
        slot_free = (state_q == IF_STATE_IDLE) ||
                    (((state_q == IF_STATE_WAIT) || (state_q == IF_STATE_FLUSH)) && ibus_rvalid);
        ibus_req  = slot_free && !skid_vld && !skid_fill && !mis_redir && !(halt_q && !redirect);
        ibus_addr = redirect ? redir_tgt : pc_q;
        gnt_ok    = ibus_req && ibus_gnt;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        halt_d   = halt_q;
        if (redirect) begin
            pc_d   = redir_tgt;
            halt_d = mis_redir;
        end
        case (state_q)
            IF_STATE_IDLE:  state_d = IF_STATE_IDLE;
            IF_STATE_WAIT: begin
                if (ibus_rvalid) begin
                    state_d = IF_STATE_IDLE;
                end else if (redirect) begin
                    state_d = IF_STATE_FLUSH;
                end
            end
            IF_STATE_FLUSH: begin
                if (ibus_rvalid) begin
                    state_d = IF_STATE_IDLE;
                end
            end
            default:        state_d = IF_STATE_IDLE;
        endcase
        if (gnt_ok) begin
            state_d  = IF_STATE_WAIT;
            req_pc_d = ibus_addr;
            pc_d     = ibus_addr + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IF_STATE_IDLE;
            pc_q     <= RESET_VECTOR;
            req_pc_q <= RESET_VECTOR;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            halt_q   <= halt_d;
        end
    end

    always_comb begin
        buf_in_vld = deliver || mis_redir;
        if (mis_redir) begin
            buf_in_dat = '{instr: CORE_NOP, pc: redirect_pc, exc: 1'b1};
        end else begin
            buf_in_dat = '{instr: ibus_rdata, pc: req_pc_q, exc: 1'b0};
        end
    end

    ifu_skid_buffer u_skid (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_vld_i   (buf_in_vld),
        .in_dat_i   (buf_in_dat),
        .flush_i    (redirect),
        .stall_i    (id_stall),
        .out_vld_o  (if_valid),
        .out_dat_o  (buf_out_dat),
        .skid_vld_o (skid_vld)
    );

    assign if_instr        = buf_out_dat.instr;
    assign if_pc           = buf_out_dat.pc;
    assign if_exc_misalign = if_valid && buf_out_dat.exc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle vector table, scoreboarded random stream, misalign corner.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_exc_misalign;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .ibus_req        (ibus_req),
        .ibus_addr       (ibus_addr),
        .ibus_gnt        (ibus_gnt),
        .ibus_rvalid     (ibus_rvalid),
        .ibus_rdata      (ibus_rdata),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .id_stall        (id_stall),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_exc_misalign (if_exc_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ctl = {gnt, rvalid, id_stall, redirect}; ex = {exp_req, exp_valid, exp_instr_is_nop}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] raddr;
        logic [31:0] rpc;
        logic [2:0]  ex;
        logic [31:0] eaddr;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] ctl, input logic [31:0] raddr, input logic [31:0] rpc,
                       input logic [2:0] ex, input logic [31:0] eaddr, input logic [31:0] epc);
        vec_t v;
        v.ctl = ctl; v.raddr = raddr; v.rpc = rpc; v.ex = ex; v.eaddr = eaddr; v.epc = epc;
        vecs.push_back(v);
    endtask

    logic [31:0] exp_q[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        logic [31:0] e;
        int          acc;
        logic        redir2;
        logic        done;

        // Streaming, 3-cycle stall with skid fill, redirect in WAIT, redirect with skid full, wrap.
        add(4'b1000, 32'h0,         32'h0,         3'b101, 32'h0,         32'h0);
        add(4'b1100, 32'h0,         32'h0,         3'b101, 32'h4,         32'h0);
        add(4'b1100, 32'h4,         32'h0,         3'b110, 32'h8,         32'h0);
        add(4'b1100, 32'h8,         32'h0,         3'b110, 32'hC,         32'h4);
        add(4'b1110, 32'hC,         32'h0,         3'b010, 32'h0,         32'h8);
        add(4'b1010, 32'h0,         32'h0,         3'b010, 32'h0,         32'h8);
        add(4'b1010, 32'h0,         32'h0,         3'b010, 32'h0,         32'h8);
        add(4'b1000, 32'h0,         32'h0,         3'b010, 32'h0,         32'h8);
        add(4'b1000, 32'h0,         32'h0,         3'b110, 32'h10,        32'hC);
        add(4'b1100, 32'h10,        32'h0,         3'b100, 32'h14,        32'hC);
        add(4'b0001, 32'h0,         32'h100,       3'b010, 32'h0,         32'h10);
        add(4'b0000, 32'h0,         32'h0,         3'b000, 32'h0,         32'h10);
        add(4'b1100, 32'h14,        32'h0,         3'b100, 32'h100,       32'h10);
        add(4'b1100, 32'h100,       32'h0,         3'b100, 32'h104,       32'h10);
        add(4'b1110, 32'h104,       32'h0,         3'b010, 32'h0,         32'h100);
        add(4'b1111, 32'hBAD0,      32'h200,       3'b010, 32'h0,         32'h100);
        add(4'b1000, 32'h0,         32'h0,         3'b100, 32'h200,       32'h100);
        add(4'b0100, 32'h200,       32'h0,         3'b100, 32'h204,       32'h100);
        add(4'b1001, 32'h0,         32'hFFFF_FFFC, 3'b110, 32'hFFFF_FFFC, 32'h200);
        add(4'b1100, 32'hFFFF_FFFC, 32'h0,         3'b100, 32'h0,         32'h200);
        add(4'b0100, 32'h0,         32'h0,         3'b110, 32'h4,         32'hFFFF_FFFC);
        add(4'b0000, 32'h0,         32'h0,         3'b110, 32'h4,         32'h0);
        add(4'b0000, 32'h0,         32'h0,         3'b100, 32'h4,         32'h0);

        rst = 1'b1; ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst         = 1'b0;
            ibus_gnt    = vecs[i].ctl[3];
            ibus_rvalid = vecs[i].ctl[2];
            ibus_rdata  = vecs[i].ctl[2] ? mem_word(vecs[i].raddr) : 32'h0;
            id_stall    = vecs[i].ctl[1];
            redirect    = vecs[i].ctl[0];
            redirect_pc = vecs[i].rpc;
            #1;
            chk1($sformatf("v%0d_req", i), ibus_req, vecs[i].ex[2]);
            if (vecs[i].ex[2]) chk32($sformatf("v%0d_addr", i), ibus_addr, vecs[i].eaddr);
            chk1($sformatf("v%0d_valid", i), if_valid, vecs[i].ex[1]);
            chk32($sformatf("v%0d_pc", i), if_pc, vecs[i].epc);
            chk32($sformatf("v%0d_instr", i), if_instr,
                  vecs[i].ex[0] ? NOP : mem_word(vecs[i].epc));
            chk1($sformatf("v%0d_exc", i), if_exc_misalign, 1'b0);
        end

        // Random stream: expected PCs queued when each redirect is driven.
        pend = 1'b0; cnt = 0; paddr = 32'h0; acc = 0; redir2 = 1'b0; done = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 24; k++) exp_q.push_back(32'h1000 + 32'(k) * 32'd4);
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            redirect = 1'b0;
            id_stall = ($urandom_range(0, 3) == 0);
            if (cyc == 0) begin
                redirect = 1'b1; redirect_pc = 32'h1000;
            end
            if (!redir2 && acc == 12) begin
                redirect = 1'b1; redirect_pc = 32'h2000; id_stall = 1'b1; redir2 = 1'b1;
                exp_q.delete();
                for (int k = 0; k < 20; k++) exp_q.push_back(32'h2000 + 32'(k) * 32'd4);
            end
            if (pend && cnt == 0) begin
                ibus_rvalid = 1'b1; ibus_rdata = mem_word(paddr); pend = 1'b0;
            end else begin
                ibus_rvalid = 1'b0; ibus_rdata = 32'hDEAD_BEEF;
                if (pend) cnt--;
            end
            ibus_gnt = ($urandom_range(0, 3) != 0);
            #1;
            if (if_valid && !id_stall) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stream_extra: got pc %h, expected no further word", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk32("stream_pc", if_pc, e);
                    chk32("stream_instr", if_instr, mem_word(e));
                    acc++;
                end
                if (redir2 && exp_q.size() == 0) done = 1'b1;
            end
            if (ibus_req && ibus_gnt) begin
                pend = 1'b1; paddr = ibus_addr; cnt = int'($urandom_range(0, 2));
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL stream_timeout: got %0d words left, expected 0", exp_q.size());
        end

        // Reset mid-stream, then the misaligned redirect corner.
        @(negedge clk);
        rst = 1'b1; ibus_gnt = 1'b0; ibus_rvalid = 1'b0; redirect = 1'b0; id_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("rst_req", ibus_req, 1'b1);
        chk32("rst_addr", ibus_addr, 32'h0);
        chk1("rst_valid", if_valid, 1'b0);
        chk32("rst_instr", if_instr, NOP);
`ifdef IF_MISALIGN_EXC_EN
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h102; ibus_gnt = 1'b1;
        #1 chk1("mis_req0", ibus_req, 1'b0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk1("mis_valid", if_valid, 1'b1);
        chk1("mis_exc", if_exc_misalign, 1'b1);
        chk32("mis_pc", if_pc, 32'h102);
        chk32("mis_instr", if_instr, NOP);
        chk1("mis_req1", ibus_req, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk1("mis_halt_req", ibus_req, 1'b0);
        end
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h200;
        #1;
        chk1("mis_resume_req", ibus_req, 1'b1);
        chk32("mis_resume_addr", ibus_addr, 32'h200);
        @(negedge clk);
        redirect = 1'b0; ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = mem_word(32'h200);
        #1;
        chk1("mis_flush_valid", if_valid, 1'b0);
        chk1("mis_flush_exc", if_exc_misalign, 1'b0);
        @(negedge clk);
        ibus_rvalid = 1'b0;
        #1;
        chk1("mis_resume_valid", if_valid, 1'b1);
        chk32("mis_resume_pc", if_pc, 32'h200);
        chk1("mis_resume_exc", if_exc_misalign, 1'b0);
`else
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h302; ibus_gnt = 1'b1;
        #1;
        chk1("align_req", ibus_req, 1'b1);
        chk32("align_addr", ibus_addr, 32'h300);
        @(negedge clk);
        redirect = 1'b0; ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = mem_word(32'h300);
        #1 chk1("align_valid0", if_valid, 1'b0);
        @(negedge clk);
        ibus_rvalid = 1'b0;
        #1;
        chk1("align_valid1", if_valid, 1'b1);
        chk32("align_pc", if_pc, 32'h300);
        chk32("align_instr", if_instr, mem_word(32'h300));
        chk1("align_exc", if_exc_misalign, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
